ddr_burst_bridge: RTL and testbench

- Sits directly downstream of the core's DDR port: it consumes the core's 512-bit cacheline requests (chip enable, index, write enable, burst mode, write data).
- It splits each request into 64-bit memory beats on a valid/ready request channel plus an in-order read-response channel.
- It reassembles read beats into a 512-bit line and returns ddr_ready / ddr_operation_done to the core.
- Non-burst requests become a single 64-bit beat.

---
 rtl/ddr_burst_bridge_if.sv | 25 ++
 rtl/ddr_burst_bridge.sv | 141 ++++++++++++++
 tb/tb_ddr_burst_bridge.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_bridge_if.sv
// Memory-side beat channel of the DDR burst bridge: valid/ready beat requests
// plus an unthrottled, in-order read-response stream.
interface ddr_burst_bridge_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 32
);
  localparam int unsigned BEAT_W = 64;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_we;
  logic [BEAT_W-1:0]         mem_wdata;
  logic                      mem_rvalid;
  logic [BEAT_W-1:0]         mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ddr_burst_bridge.sv
// Splits 512-bit cacheline requests from the core into 64-bit memory beats and
// reassembles in-order read responses into a line.
module ddr_burst_bridge #(
  parameter int unsigned MEM_ADDR_WIDTH = 32,
  parameter int unsigned BURST_BEATS    = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ddr_chip_enable,
  input  logic [63:0]          ddr_index,
  input  logic                 ddr_write_enable,
  input  logic                 ddr_burst_mode,
  input  logic [511:0]         ddr_write_data,
  output logic [511:0]         ddr_read_data,
  output logic                 ddr_operation_done,
  output logic                 ddr_ready,
  output logic                 protocol_err,
  ddr_burst_bridge_if.master   mem
);

  localparam int unsigned AW     = MEM_ADDR_WIDTH;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   rsp_cnt;
  logic [CNT_W-1:0]   term;
  logic               is_write;
  logic [LINE_W-1:0]  wline;

  logic               accept_c;
  logic               req_last_c;
  logic               rsp_expected_c;
  logic               rsp_take_c;
  logic [CNT_W-1:0]   rsp_cnt_nxt_c;
  logic [AW-1:0]      launch_addr_c;
  logic               unused_index;

  // Bits above the dword address space are truncated by design.
  assign unused_index = ^ddr_index[63:AW];

  // Handshake / response bookkeeping; a response is legal only while a read beat is outstanding.
  always_comb begin
    accept_c       = mem.mem_req_valid & mem.mem_req_ready;
    req_last_c     = accept_c && (req_cnt == (term - CNT_W'(1)));
    rsp_expected_c = ((state == ISSUE) || (state == WAIT)) && !is_write && (rsp_cnt != req_cnt);
    rsp_take_c     = mem.mem_rvalid & rsp_expected_c;
    rsp_cnt_nxt_c  = rsp_cnt + CNT_W'(rsp_take_c);
    launch_addr_c  = ddr_burst_mode ? {ddr_index[AW-1:3], 3'b000} : ddr_index[AW-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      req_cnt            <= '0;
      rsp_cnt            <= '0;
      term               <= '0;
      is_write           <= 1'b0;
      wline              <= '0;
      ddr_ready          <= 1'b1;
      ddr_operation_done <= 1'b0;
      ddr_read_data      <= '0;
      protocol_err       <= 1'b0;
      mem.mem_req_valid  <= 1'b0;
      mem.mem_addr       <= '0;
      mem.mem_we         <= 1'b0;
      mem.mem_wdata      <= '0;
    end else begin
      ddr_operation_done <= 1'b0;

      if (mem.mem_rvalid && !rsp_expected_c) begin
        protocol_err <= 1'b1;
      end

      // Response k lands in slot k; unwritten slots keep their old contents.
      if (rsp_take_c) begin
        ddr_read_data[BEAT_W*rsp_cnt[2:0] +: BEAT_W] <= mem.mem_rdata;
        rsp_cnt <= rsp_cnt_nxt_c;
      end

      case (state)
        IDLE: begin
          if (ddr_chip_enable) begin
            is_write          <= ddr_write_enable;
            term              <= ddr_burst_mode ? CNT_W'(BURST_BEATS) : CNT_W'(1);
            req_cnt           <= '0;
            rsp_cnt           <= '0;
            mem.mem_addr      <= launch_addr_c;
            mem.mem_we        <= ddr_write_enable;
            mem.mem_wdata     <= ddr_write_data[BEAT_W-1:0];
            wline             <= ddr_write_data >> BEAT_W;
            mem.mem_req_valid <= 1'b1;
            ddr_ready         <= 1'b0;
            if (!ddr_write_enable && !ddr_burst_mode) begin
              ddr_read_data[LINE_W-1:BEAT_W] <= '0;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (accept_c) begin
            req_cnt <= req_cnt + CNT_W'(1);
            if (req_last_c) begin
              mem.mem_req_valid <= 1'b0;
              if (is_write || (rsp_cnt_nxt_c == term)) begin
                state              <= DONE;
                ddr_operation_done <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              mem.mem_addr  <= mem.mem_addr + AW'(1);
              mem.mem_wdata <= wline[BEAT_W-1:0];
              wline         <= wline >> BEAT_W;
            end
          end
        end

        WAIT: begin
          if (rsp_cnt_nxt_c == term) begin
            state              <= DONE;
            ddr_operation_done <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          ddr_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_bridge.sv
// Directed bench for ddr_burst_bridge: beat scoreboard, 1-cycle read memory
// model, latency, stall-hold, protocol-error and mid-burst reset checks.
module tb_ddr_burst_bridge;
  localparam int unsigned AW = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ddr_chip_enable = 1'b0;
  logic [63:0]  ddr_index = '0;
  logic         ddr_write_enable = 1'b0;
  logic         ddr_burst_mode = 1'b0;
  logic [511:0] ddr_write_data = '0;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         protocol_err;

  always #5 clock = ~clock;

  ddr_burst_bridge_if #(.MEM_ADDR_WIDTH(AW)) mem ();

  ddr_burst_bridge #(.MEM_ADDR_WIDTH(AW), .BURST_BEATS(8)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready),
    .protocol_err       (protocol_err),
    .mem                (mem)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [63:0]   wdata;
  } beat_t;

  beat_t       exp_beats[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          c0 = 0;
  bit          toggle_rdy = 1'b0;
  bit          inject = 1'b0;
  bit          pend = 1'b0;
  bit          stalled = 1'b0;
  bit          rd_ovr_en = 1'b0;
  logic [63:0] rd_ovr = '0;
  logic [63:0] pend_data = '0;
  beat_t       stall_beat;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: accepts beats, returns read data one cycle later, checks beats.
  always @(negedge clock) begin
    beat_t b, e;
    bit    have;
    if (!reset_n) begin
      pend = 1'b0;
      stalled = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_req_ready = 1'b1;
    end else begin
      mem.mem_rvalid = pend | inject;
      mem.mem_rdata  = pend ? pend_data : 64'h0BAD;
      pend = 1'b0;
      inject = 1'b0;
      if (stalled)
        chk("stall_hold", {mem.mem_req_valid, mem.mem_addr, mem.mem_we, mem.mem_wdata},
            {1'b1, stall_beat});
      mem.mem_req_ready = toggle_rdy ? ~mem.mem_req_ready : 1'b1;
      b = '{addr: mem.mem_addr, we: mem.mem_we, wdata: mem.mem_wdata};
      stalled = mem.mem_req_valid && !mem.mem_req_ready;
      stall_beat = b;
      if (mem.mem_req_valid && mem.mem_req_ready) begin
        beats++;
        have = (exp_beats.size() != 0);
        e = have ? exp_beats.pop_front() : '0;
        if (!b.we) b.wdata = '0;
        if (!e.we) e.wdata = '0;
        chk("beat", {1'b1, b}, {have, e});
        if (!mem.mem_we) begin
          pend = 1'b1;
          pend_data = rd_ovr_en ? rd_ovr : 64'(mem.mem_addr);
        end
      end
      if (ddr_operation_done) done_cnt++;
    end
  end

  task automatic issue(input bit we, input bit burst, input logic [63:0] idx,
                       input logic [511:0] wl, input bit hold);
    logic [AW-1:0] base;
    int n;
    @(negedge clock);
    c0 = cyc;
    ddr_chip_enable  = 1'b1;
    ddr_index        = idx;
    ddr_write_enable = we;
    ddr_burst_mode   = burst;
    ddr_write_data   = wl;
    base = burst ? {idx[AW-1:3], 3'b000} : idx[AW-1:0];
    n = burst ? 8 : 1;
    for (int i = 0; i < n; i++)
      exp_beats.push_back('{addr: base + AW'(i), we: we, wdata: wl[64*i +: 64]});
    if (!hold) begin
      @(negedge clock);
      ddr_chip_enable = 1'b0;
    end
  endtask

  task automatic wait_done(output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (ddr_operation_done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  function automatic logic [511:0] addr_line(input logic [AW-1:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = 64'(base + AW'(i));
    return l;
  endfunction

  initial begin
    int at, b0, d0;
    bit ok;
    logic [511:0] wl, line4;

    mem.mem_rvalid = 1'b0;
    mem.mem_rdata = '0;
    mem.mem_req_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_ready", ddr_ready, 1);
    chk("rst_done", ddr_operation_done, 0);
    chk("rst_req_valid", mem.mem_req_valid, 0);
    chk("rst_addr_we_wdata", {mem.mem_addr, mem.mem_we, mem.mem_wdata}, 0);
    chk("rst_read_data", ddr_read_data, 0);
    chk("rst_perr", protocol_err, 0);
    reset_n = 1'b1;

    // Burst read, base aligned down from 0x1005
    issue(1'b0, 1'b1, 64'h1005, '0, 1'b0);
    wait_done(at, ok);
    chk("br_done_seen", ok, 1);
    chk("br_latency", at - c0, 10);
    chk("br_line", ddr_read_data, addr_line(32'h1000));
    chk("br_beats_left", exp_beats.size(), 0);
    @(negedge clock);
    chk("br_pulse_once", ddr_operation_done, 0);
    chk("br_ready_after", ddr_ready, 1);

    // Burst write with stalling memory
    for (int i = 0; i < 8; i++) wl[64*i +: 64] = 64'(32'hA0 + i);
    toggle_rdy = 1'b1;
    @(posedge clock);
    d0 = done_cnt;
    issue(1'b1, 1'b1, 64'h20, wl, 1'b0);
    wait_done(at, ok);
    chk("bw_done_seen", ok, 1);
    @(negedge clock);
    toggle_rdy = 1'b0;
    chk("bw_pulse_once", ddr_operation_done, 0);
    chk("bw_ready_after", ddr_ready, 1);
    chk("bw_beats_left", exp_beats.size(), 0);
    @(posedge clock);
    chk("bw_done_count", done_cnt - d0, 1);

    // Single read clears upper line
    rd_ovr_en = 1'b1;
    rd_ovr = 64'hDEADBEEF;
    issue(1'b0, 1'b0, 64'h7, '0, 1'b0);
    wait_done(at, ok);
    chk("sr_done_seen", ok, 1);
    chk("sr_latency", at - c0, 3);
    chk("sr_line", ddr_read_data, {448'h0, 64'hDEADBEEF});
    rd_ovr_en = 1'b0;

    // Chip enable held high through a whole burst read
    @(posedge clock);
    b0 = beats;
    d0 = done_cnt;
    issue(1'b0, 1'b1, 64'h3000, '0, 1'b1);
    wait_done(at, ok);
    ddr_chip_enable = 1'b0;
    chk("ce_done_seen", ok, 1);
    chk("ce_line", ddr_read_data, addr_line(32'h3000));
    line4 = ddr_read_data;
    repeat (12) @(negedge clock);
    chk("ce_idle_valid", mem.mem_req_valid, 0);
    @(posedge clock);
    chk("ce_beat_count", beats - b0, 8);
    chk("ce_done_count", done_cnt - d0, 1);

    // Stray response in IDLE
    chk("pe_clear_before", protocol_err, 0);
    inject = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("pe_set", protocol_err, 1);
    chk("pe_data_discarded", ddr_read_data, line4);
    issue(1'b0, 1'b1, 64'h2000, '0, 1'b0);
    wait_done(at, ok);
    chk("pe_read_done", ok, 1);
    chk("pe_read_line", ddr_read_data, addr_line(32'h2000));
    chk("pe_sticky", protocol_err, 1);

    // Reset in the middle of a burst write
    for (int i = 0; i < 8; i++) wl[64*i +: 64] = {32'hC0DE0000, 32'(i)};
    @(posedge clock);
    b0 = beats;
    d0 = done_cnt;
    issue(1'b1, 1'b1, 64'h40, wl, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      if (beats - b0 >= 4) break;
    end
    chk("mr_beats_before_reset", beats - b0, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid_dropped", mem.mem_req_valid, 0);
    chk("mr_ready", ddr_ready, 1);
    chk("mr_no_done", ddr_operation_done, 0);
    exp_beats.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(posedge clock);
    chk("mr_done_count", done_cnt - d0, 0);
    chk("mr_perr_cleared", protocol_err, 0);
    chk("mr_rdata_cleared", ddr_read_data, 0);
    issue(1'b1, 1'b1, 64'h40, wl, 1'b0);
    wait_done(at, ok);
    chk("mr_rewrite_done", ok, 1);
    chk("mr_rewrite_latency", at - c0, 9);
    chk("mr_rewrite_beats_left", exp_beats.size(), 0);
    @(negedge clock);
    chk("mr_ready_after", ddr_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
